prim_dup_count: RTL
===================

Name: prim_dup_count

Overview:
- Hardened saturating up/down counter for security-relevant counters (retry counts, FSM timers, address walkers).
- Keeps two redundant state registers: a primary up-count and a complementary shadow down-count.
- Flags any mismatch between them as a sticky fault.
- Outputs feed the generic buffer primitive downstream so synthesis cannot merge or optimise away the redundant copies.

Parameters:
- Width, 8, counter width in bits (legal range 2..32).
- ResetValue, 0, primary count after reset (must be < 2**Width).
- EnableAlertLatch, 1, 1 = err_o sticky until reset; 0 = err_o reflects the current-cycle mismatch only.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous active-high reset.
- clr_i  input  1  force count to 0.
- set_i  input  1  load set_cnt_i.
- set_cnt_i  input  Width  load value.
- incr_en_i  input  1  add step_i.
- decr_en_i  input  1  subtract step_i.
- step_i  input  Width  increment/decrement amount.
- cnt_o  output  Width  primary count (registered).
- cnt_next_o  output  Width  combinational next primary count.
- sat_o  output  1  high when the last update clipped at 0 or MaxVal (registered).
- err_o  output  1  redundancy fault.

Behaviour:
- One clock; reset is synchronous and active-high.
- MaxVal = 2**Width-1.
- State: up_q (Width), dn_q (Width), sat_q, err_q.
- Invariant: up_q + dn_q == MaxVal, i.e. dn_q == ~up_q.
- Reset (rst_i high at a clock edge):
  - up_q=ResetValue, dn_q=MaxVal-ResetValue, sat_q=0, err_q=0.
  - Reset overrides every other input in the same cycle.
- Update priority, evaluated per cycle:
  1. clr_i: up=0, dn=MaxVal.
  2. set_i: up=set_cnt_i, dn=~set_cnt_i.
  3. incr_en_i and decr_en_i both high: hold, sat=0.
  4. incr_en_i only: up_next = min(up_q+step_i, MaxVal); dn_next = max(dn_q-step_i, 0).
  5. decr_en_i only: up_next = max(up_q-step_i, 0); dn_next = min(dn_q+step_i, MaxVal).
  6. None: hold.
- Arithmetic: use Width+1 bits for carry/borrow detection, then clip. No wrap-around ever.
- sat_q=1 only when a case-4/5 update clips. It clears on any non-clipping update, clr, set, or hold.
- Each register computes its own next value from its own state. The shadow path must not be derived from up_q, so a single-register fault stays detectable.
- cnt_o = up_q. cnt_next_o = up_next, combinational, zero latency.
- Mismatch = (up_q != ~dn_q), combinational on registered state.
- err_o:
  - EnableAlertLatch=1: err_q set on mismatch, cleared only by rst_i; err_o = err_q | mismatch, so it asserts in the same cycle as the fault.
  - EnableAlertLatch=0: err_o = mismatch.
- clr/set do not clear err_q.
- step_i=0 with an enable behaves as hold, sat=0.
- Counter output latency: 1 cycle from input to cnt_o.

Test Plan:
- Reset/basic count: Width=8, ResetValue=5, rst_i for 2 cycles -> cnt_o=5, err_o=0, sat_o=0. Then incr_en_i=1, step_i=3 for 4 cycles -> cnt_o 8,11,14,17; cnt_next_o leads cnt_o by one cycle.
- Saturation high: set_cnt_i=250, set_i pulse, then incr step_i=10 -> cnt_o=255, sat_o=1. Next cycle hold -> cnt_o=255, sat_o=0.
- Saturation low: cnt_o=3, decr step_i=7 -> cnt_o=0, sat_o=1. Further decr step_i=1 -> cnt_o=0, sat_o=1.
- Priority and simultaneity:
  - clr_i+set_i+incr_en_i together -> cnt_o=0.
  - set_i+decr_en_i with set_cnt_i=40 -> cnt_o=40.
  - incr_en_i+decr_en_i -> cnt_o unchanged, sat_o=0.
- Fault detection: force dn_q bit0 inverted for one cycle at cnt=17 -> err_o=1 in that cycle. With EnableAlertLatch=1, err_o stays 1 after release and after clr_i, clearing only on rst_i. With EnableAlertLatch=0, err_o returns to 0 after release.
- Reset mid-operation: rst_i asserted in the same cycle as incr_en_i, step_i=9 at cnt=100 -> next cnt_o=ResetValue(5), sat_o=0, err_o=0. Counting resumes correctly the cycle after rst_i drops.

Source files
------------

// File: rtl/prim_dup_count.sv
// Hardened saturating up/down counter with a complementary shadow register.
// Any disagreement between the two copies raises err_o.
module prim_dup_count #(
    parameter int unsigned Width            = 8,
    parameter int unsigned ResetValue       = 0,
    parameter bit          EnableAlertLatch = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic [Width-1:0] set_cnt_i,
    input  logic             incr_en_i,
    input  logic             decr_en_i,
    input  logic [Width-1:0] step_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_next_o,
    output logic             sat_o,
    output logic             err_o
);

    localparam logic [Width-1:0] MaxVal   = '1;
    localparam logic [Width-1:0] ResetCnt = ResetValue[Width-1:0];

    logic [Width-1:0] r_up;
    logic [Width-1:0] r_dn;
    logic             r_sat;
    logic             r_err;

    logic [Width:0]   w_up_add;
    logic [Width:0]   w_up_sub;
    logic [Width:0]   w_dn_add;
    logic [Width:0]   w_dn_sub;
    logic [Width-1:0] w_up_next;
    logic [Width-1:0] w_dn_next;
    logic             w_sat_next;
    logic             w_mismatch;

    // Each copy does its own carry/borrow arithmetic so a fault in one is never masked.
    assign w_up_add = {1'b0, r_up} + {1'b0, step_i};
    assign w_up_sub = {1'b0, r_up} - {1'b0, step_i};
    assign w_dn_add = {1'b0, r_dn} + {1'b0, step_i};
    assign w_dn_sub = {1'b0, r_dn} - {1'b0, step_i};

    always_comb begin
        w_up_next  = r_up;
        w_dn_next  = r_dn;
        w_sat_next = 1'b0;
        if (clr_i) begin
            w_up_next = '0;
            w_dn_next = MaxVal;
        end else if (set_i) begin
            w_up_next = set_cnt_i;
            w_dn_next = ~set_cnt_i;
        end else if (incr_en_i && !decr_en_i) begin
            w_up_next  = w_up_add[Width] ? MaxVal : w_up_add[Width-1:0];
            w_dn_next  = w_dn_sub[Width] ? '0 : w_dn_sub[Width-1:0];
            w_sat_next = w_up_add[Width];
        end else if (decr_en_i && !incr_en_i) begin
            w_up_next  = w_up_sub[Width] ? '0 : w_up_sub[Width-1:0];
            w_dn_next  = w_dn_add[Width] ? MaxVal : w_dn_add[Width-1:0];
            w_sat_next = w_up_sub[Width];
        end
    end

    assign w_mismatch = (r_up != ~r_dn);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_up  <= ResetCnt;
            r_dn  <= MaxVal - ResetCnt;
            r_sat <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_up  <= w_up_next;
            r_dn  <= w_dn_next;
            r_sat <= w_sat_next;
            r_err <= r_err | w_mismatch;
        end
    end

    assign cnt_o      = r_up;
    assign cnt_next_o = w_up_next;
    assign sat_o      = r_sat;
    assign err_o      = EnableAlertLatch ? (r_err | w_mismatch) : w_mismatch;

endmodule
